// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, ALU/extender/PC-select
// constants, instruction opcode/funct codes and the decoded instruction class.
package mips_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_SUBU = 5'd2;
  localparam logic [4:0] ALUOp_OR   = 5'd4;

  localparam logic [1:0] EXT_ZERO   = 2'd0;
  localparam logic [1:0] EXT_SIGNED = 2'd1;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [5:0] INSTR_RTYPE_OP   = 6'h00;
  localparam logic [5:0] INSTR_ORI_OP     = 6'h0D;
  localparam logic [5:0] INSTR_LW_OP      = 6'h23;
  localparam logic [5:0] INSTR_SW_OP      = 6'h2B;
  localparam logic [5:0] INSTR_BEQ_OP     = 6'h04;
  localparam logic [5:0] INSTR_J_OP       = 6'h02;
  localparam logic [5:0] INSTR_ADDU_FUNCT = 6'h21;
  localparam logic [5:0] INSTR_SUBU_FUNCT = 6'h23;

  // One-hot instruction class; legal is the OR of the class bits.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic legal;
  } instr_cls_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Datapath <-> control bundle. master = datapath side, slave = control FSM.
interface mips_mc_ctrl_if #(
  parameter int ALUOP_W = 5,
  parameter int EXTOP_W = 2
);
  logic               en;
  logic [5:0]         opcode;
  logic [5:0]         func;
  logic               compare;
  logic               mem_ready;
  logic               pc_wr;
  logic [1:0]         pc_src;
  logic               ir_wr;
  logic               reg_wr;
  logic               reg_dst;
  logic               alu_src;
  logic [EXTOP_W-1:0] ext_op;
  logic [ALUOP_W-1:0] aluctr;
  logic               mem_rd;
  logic               mem_wr;
  logic               mem_to_reg;
  logic               illegal;
  logic [2:0]         state_o;

  modport master (
    output en, opcode, func, compare, mem_ready,
    input  pc_wr, pc_src, ir_wr, reg_wr, reg_dst, alu_src, ext_op, aluctr,
           mem_rd, mem_wr, mem_to_reg, illegal, state_o
  );

  modport slave (
    input  en, opcode, func, compare, mem_ready,
    output pc_wr, pc_src, ir_wr, reg_wr, reg_dst, alu_src, ext_op, aluctr,
           mem_rd, mem_wr, mem_to_reg, illegal, state_o
  );
endinterface

// File: rtl/mips_mc_decode.sv
// Opcode/funct to one-hot instruction class plus legal flag.
module mips_mc_decode
  import mips_mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output instr_cls_t cls
);
  always_comb begin
    cls = '0;
    case (opcode)
      INSTR_RTYPE_OP: begin
        cls.addu = (func == INSTR_ADDU_FUNCT);
        cls.subu = (func == INSTR_SUBU_FUNCT);
      end
      INSTR_ORI_OP: cls.ori = 1'b1;
      INSTR_LW_OP:  cls.lw  = 1'b1;
      INSTR_SW_OP:  cls.sw  = 1'b1;
      INSTR_BEQ_OP: cls.beq = 1'b1;
      INSTR_J_OP:   cls.j   = 1'b1;
      default: ;
    endcase
    cls.legal = cls.addu | cls.subu | cls.ori | cls.lw | cls.sw | cls.beq | cls.j;
  end
endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Optional MEM_WAIT_EN: MEM stalls until mem_ready; otherwise MEM is one cycle.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int EXTOP_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.slave  bus
);
  state_t             state, nxt;
  instr_cls_t         cls;
  logic [ALUOP_W-1:0] alu_sel;
  logic [EXTOP_W-1:0] ext_sel;
  logic               src_sel;
  logic               mem_done;

  mips_mc_decode u_dec (.opcode(bus.opcode), .func(bus.func), .cls(cls));

  always_ff @(posedge clk) begin
    if (rst)         state <= S_FETCH;
    else if (bus.en) state <= nxt;
  end

  // ALU/extender selects set up in EXEC and held through MEM/WB.
  always_comb begin
    alu_sel = ALUOP_W'(ALUOp_NOP);
    ext_sel = EXTOP_W'(EXT_ZERO);
    src_sel = 1'b0;
    if (cls.addu) alu_sel = ALUOP_W'(ALUOp_ADDU);
    if (cls.subu || cls.beq) alu_sel = ALUOP_W'(ALUOp_SUBU);
    if (cls.ori) begin
      alu_sel = ALUOP_W'(ALUOp_OR);
      src_sel = 1'b1;
    end
    if (cls.lw || cls.sw) begin
      alu_sel = ALUOP_W'(ALUOp_ADDU);
      ext_sel = EXTOP_W'(EXT_SIGNED);
      src_sel = 1'b1;
    end
  end

`ifdef MEM_WAIT_EN
  assign mem_done = bus.mem_ready;
`else
  // mem_ready has no effect here; it is folded in only so the port is read.
  assign mem_done = bus.mem_ready | 1'b1;
`endif

  always_comb begin
    nxt            = state;
    bus.pc_wr      = 1'b0;
    bus.pc_src     = PC_SRC_PC4;
    bus.ir_wr      = 1'b0;
    bus.reg_wr     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.ext_op     = '0;
    bus.aluctr     = '0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;
    bus.state_o    = state;
    if (rst) begin
      nxt = S_FETCH;
    end else begin
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
        bus.aluctr  = alu_sel;
        bus.ext_op  = ext_sel;
        bus.alu_src = src_sel;
      end
      case (state)
        S_FETCH: begin
          bus.ir_wr = bus.en;
          bus.pc_wr = bus.en;
          nxt       = S_DECODE;
        end
        S_DECODE: begin
          if (cls.legal) nxt = S_EXEC;
          else begin
            bus.illegal = bus.en;
            nxt         = S_FETCH;
          end
        end
        S_EXEC: begin
          if (cls.beq) begin
            bus.pc_src = PC_SRC_BR;
            bus.pc_wr  = bus.en & bus.compare;
            nxt        = S_FETCH;
          end else if (cls.j) begin
            bus.pc_src = PC_SRC_JMP;
            bus.pc_wr  = bus.en;
            nxt        = S_FETCH;
          end else if (cls.lw || cls.sw) nxt = S_MEM;
          else nxt = S_WB;
        end
        S_MEM: begin
          bus.mem_rd = bus.en & cls.lw;
          bus.mem_wr = bus.en & cls.sw;
          if (mem_done) nxt = cls.lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          bus.reg_wr     = bus.en;
          bus.reg_dst    = cls.addu | cls.subu;
          bus.mem_to_reg = cls.lw;
          nxt            = S_FETCH;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl; MEM wait checks only when MEM_WAIT_EN is defined.
module tb_mips_mc_ctrl;
  import mips_mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl_if #(.ALUOP_W(5), .EXTOP_W(2)) bus ();
  mips_mc_ctrl #(.ALUOP_W(5), .EXTOP_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH back to FETCH, recording what it saw (no checking here).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, output int cyc,
                           output logic rd, output logic m2r, output logic [4:0] alu,
                           output int wr_cnt);
    bus.opcode = op;
    bus.func   = fn;
    #1;
    cyc = 0; rd = 1'bx; m2r = 1'bx; alu = 5'bx; wr_cnt = 0;
    do begin
      if (bus.state_o == 3'd2) alu = bus.aluctr;
      if (bus.state_o == 3'd4) begin rd = bus.reg_dst; m2r = bus.mem_to_reg; end
      wr_cnt += int'(bus.mem_wr) + int'(bus.reg_wr);
      tick();
      cyc++;
    end while (bus.state_o != 3'd0 && cyc < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.opcode = 6'h23; bus.func = 6'h00;
    bus.compare = 1'b0; bus.mem_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", bus.state_o); end
    n_cmp++;
    if ({bus.pc_wr, bus.ir_wr, bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.illegal} !== 6'b0) begin
      n_bad++; $display("FAIL reset_enables got %b want 000000",
                        {bus.pc_wr, bus.ir_wr, bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.illegal});
    end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if ({bus.ir_wr, bus.pc_wr, bus.pc_src} !== 4'b1100) begin
      n_bad++; $display("FAIL first_fetch got ir/pc/src %b want 1100", {bus.ir_wr, bus.pc_wr, bus.pc_src});
    end
    // leave the LW that was fetched by running it out
    tick(); tick(); tick(); tick(); tick();
    n_cmp++;
    if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL post_reset_lw got %0d want 0", bus.state_o); end
  endtask

  task automatic test_sequence();
    logic [5:0] ops [6] = '{6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
    int         exp_cyc [6] = '{4, 4, 5, 4, 3, 3};
    int         exp_wr [6] = '{1, 1, 1, 1, 0, 0};
    logic [4:0] exp_alu [6] = '{5'd1, 5'd4, 5'd1, 5'd1, 5'd2, 5'd0};
    int cyc, wrc; logic rd, m2r; logic [4:0] alu;
    for (int i = 0; i < 6; i++) begin
      run_instr(ops[i], 6'h21, cyc, rd, m2r, alu, wrc);
      n_cmp++;
      if (cyc !== exp_cyc[i]) begin n_bad++; $display("FAIL cycles[%0d] got %0d want %0d", i, cyc, exp_cyc[i]); end
      n_cmp++;
      if (alu !== exp_alu[i]) begin n_bad++; $display("FAIL exec_aluctr[%0d] got %0d want %0d", i, alu, exp_alu[i]); end
      n_cmp++;
      if (wrc !== exp_wr[i]) begin n_bad++; $display("FAIL write_count[%0d] got %0d want %0d", i, wrc, exp_wr[i]); end
      if (i <= 2) begin
        n_cmp++;
        if (rd !== (i == 0)) begin n_bad++; $display("FAIL wb_reg_dst[%0d] got %b want %b", i, rd, i == 0); end
        n_cmp++;
        if (m2r !== (i == 2)) begin n_bad++; $display("FAIL wb_mem_to_reg[%0d] got %b want %b", i, m2r, i == 2); end
      end
    end
  endtask

  task automatic test_branch();
    for (int c = 1; c >= 0; c--) begin
      bus.opcode = 6'h04; bus.compare = c[0];
      tick(); tick();
      n_cmp++;
      if ({bus.state_o, bus.pc_wr, bus.pc_src} !== {3'd2, c[0], 2'd1}) begin
        n_bad++; $display("FAIL beq_exec cmp=%0d got st/pcwr/src %b want %b", c,
                          {bus.state_o, bus.pc_wr, bus.pc_src}, {3'd2, c[0], 2'd1});
      end
      tick();
      n_cmp++;
      if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL beq_return cmp=%0d got %0d want 0", c, bus.state_o); end
    end
    bus.compare = 1'b0;
  endtask

  task automatic test_illegal();
    logic [11:0] bad [2] = '{{6'h3F, 6'h00}, {6'h00, 6'h20}};
    for (int i = 0; i < 2; i++) begin
      bus.opcode = bad[i][11:6]; bus.func = bad[i][5:0];
      tick();
      n_cmp++;
      if ({bus.state_o, bus.illegal, bus.reg_wr, bus.mem_wr} !== 6'b001100) begin
        n_bad++; $display("FAIL illegal_decode[%0d] got st/ill/rw/mw %b want 001100", i,
                          {bus.state_o, bus.illegal, bus.reg_wr, bus.mem_wr});
      end
      tick();
      n_cmp++;
      if ({bus.state_o, bus.illegal} !== 4'b0000) begin
        n_bad++; $display("FAIL illegal_next[%0d] got st/ill %b want 0000", i, {bus.state_o, bus.illegal});
      end
    end
  endtask

  task automatic test_stall();
    int wr = 0;
    bus.opcode = 6'h2B;
    tick(); tick(); tick();
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus.state_o !== 3'd3 || bus.mem_wr !== 1'b0) wr++;
      tick();
    end
    n_cmp++;
    if (wr !== 0) begin n_bad++; $display("FAIL stall_hold bad_cycles %0d want 0", wr); end
    bus.en = 1'b1; #1;
    n_cmp++;
    if (bus.mem_wr !== 1'b1) begin n_bad++; $display("FAIL stall_release mem_wr got %b want 1", bus.mem_wr); end
    tick();
    n_cmp++;
    if ({bus.state_o, bus.mem_wr} !== 4'b0000) begin
      n_bad++; $display("FAIL stall_after got st/mw %b want 0000", {bus.state_o, bus.mem_wr});
    end
  endtask

  task automatic test_mem_reset();
    bus.opcode = 6'h23;
    tick(); tick(); tick();
    rst = 1'b1; #1;
    n_cmp++;
    if ({bus.reg_wr, bus.mem_rd, bus.pc_wr, bus.ir_wr} !== 4'b0) begin
      n_bad++; $display("FAIL rst_in_mem got rw/mr/pw/iw %b want 0000",
                        {bus.reg_wr, bus.mem_rd, bus.pc_wr, bus.ir_wr});
    end
    tick();
    rst = 1'b0; #1;
    n_cmp++;
    if ({bus.state_o, bus.reg_wr} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_in_mem_next got st/rw %b want 0000", {bus.state_o, bus.reg_wr});
    end
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    int rd_cyc = 0;
    bus.opcode = 6'h23; bus.mem_ready = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      rd_cyc += int'(bus.mem_rd && bus.state_o == 3'd3);
      tick();
    end
    bus.mem_ready = 1'b1; #1;
    rd_cyc += int'(bus.mem_rd && bus.state_o == 3'd3);
    tick();
    n_cmp++;
    if (rd_cyc !== 5) begin n_bad++; $display("FAIL wait_mem_rd got %0d want 5", rd_cyc); end
    n_cmp++;
    if (bus.state_o !== 3'd4) begin n_bad++; $display("FAIL wait_to_wb got %0d want 4", bus.state_o); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_branch();
    test_illegal();
    test_stall();
    test_mem_reset();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
